// File: rtl/input_loop_pkg.sv
// Shared types and helpers for the input-loop MAC: width derivation,
// accumulator FSM state encoding and the round/saturate helper.
package input_loop_pkg;

  localparam int DEF_TN    = 4;
  localparam int DEF_W     = 16;
  localparam int DEF_FRAC  = 8;
  localparam int DEF_ACC_W = 40;

  // round_sat works on fixed, generously sized containers so one function
  // serves every parameterisation (ACC_W <= 128, W <= 64).
  localparam int RS_ACC_W = 128;
  localparam int RS_VAL_W = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic                sat;
    logic [RS_VAL_W-1:0] value;
  } round_sat_t;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic int tree_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  // Round half up by dropping frac bits, then clip to a signed w-bit range.
  function automatic round_sat_t round_sat(input logic signed [RS_ACC_W-1:0] acc,
                                           input int frac, input int w);
    logic signed [RS_ACC_W-1:0] one;
    logic signed [RS_ACC_W-1:0] half;
    logic signed [RS_ACC_W-1:0] r;
    logic signed [RS_ACC_W-1:0] hi;
    logic signed [RS_ACC_W-1:0] lo;
    round_sat_t res;
    one  = RS_ACC_W'(1);
    half = one <<< (frac - 1);
    r    = (acc + half) >>> frac;
    hi   = (one <<< (w - 1)) - one;
    lo   = -(one <<< (w - 1));
    res.sat = (r > hi) || (r < lo);
    if (r > hi) begin
      res.value = hi[RS_VAL_W-1:0];
    end else if (r < lo) begin
      res.value = lo[RS_VAL_W-1:0];
    end else begin
      res.value = r[RS_VAL_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/input_loop_mac_adder_tree.sv
// Combinational signed adder tree; non-power-of-two lane counts are padded
// with zero leaves so every level halves cleanly.
module adder_tree #(
  parameter int N_p    = 4,
  parameter int IN_W_p = 32,
  parameter int OUT_W  = IN_W_p + $clog2(N_p)
) (
  input  logic [N_p*IN_W_p-1:0] in_i,
  output logic signed [OUT_W-1:0] sum_o
);

  localparam int LEVELS = $clog2(N_p);
  localparam int P      = 1 << LEVELS;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic signed [OUT_W-1:0] node [P >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_in
        if (i < N_p) begin : g_real
          assign node[i] = OUT_W'($signed(in_i[i*IN_W_p +: IN_W_p]));
        end else begin : g_pad
          assign node[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < (P >> l); i++) begin : g_sum
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign sum_o = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/input_loop_mac.sv
// Pipelined multiply / adder-tree / accumulate engine for one output pixel
// across input-channel tiles, with rounded and saturated fixed-point output.
module input_loop_mac
  import input_loop_pkg::*;
#(
  parameter int Tn_p    = DEF_TN,
  parameter int W_p     = DEF_W,
  parameter int FRAC_p  = DEF_FRAC,
  parameter int ACC_W_p = DEF_ACC_W
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      first_i,
  input  logic                      last_i,
  input  logic [Tn_p-1:0][W_p-1:0]  fm_i,
  input  logic [Tn_p-1:0][W_p-1:0]  weights_i,
  input  logic [W_p-1:0]            fm_init_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [W_p-1:0]            fm_o,
  output logic                      sat_o,
  output acc_state_e                acc_state_o
);

  localparam int PROD_W = prod_width(W_p);
  localparam int TREE_W = tree_width(W_p, Tn_p);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a producer holding valid keeps
  // its data stable until the transfer. The whole pipe moves as one unit, so a
  // stalled output blocks every stage and the input.
  logic advance;
  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  // Stage S1: per-lane products
  logic [Tn_p-1:0][PROD_W-1:0] prod;
  logic [Tn_p-1:0][PROD_W-1:0] s1_prod;
  logic                        s1_valid;
  logic                        s1_first;
  logic                        s1_last;
  logic [W_p-1:0]              s1_init;

  always_comb begin
    prod = '0;
    for (int i = 0; i < Tn_p; i++) begin
      prod[i] = PROD_W'($signed(fm_i[i])) * PROD_W'($signed(weights_i[i]));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_init  <= '0;
      s1_prod  <= '0;
    end else if (advance) begin
      s1_valid <= valid_i;
      s1_first <= first_i;
      s1_last  <= last_i;
      s1_init  <= fm_init_i;
      s1_prod  <= prod;
    end
  end

  // Stage S2: reduced sum
  logic signed [TREE_W-1:0]  tree_sum;
  logic signed [ACC_W_p-1:0] s2_sum;
  logic                      s2_valid;
  logic                      s2_first;
  logic                      s2_last;
  logic signed [W_p-1:0]     s2_init;

  adder_tree #(
    .N_p    (Tn_p),
    .IN_W_p (PROD_W),
    .OUT_W  (TREE_W)
  ) u_adder_tree (
    .in_i  (s1_prod),
    .sum_o (tree_sum)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_init  <= '0;
      s2_sum   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_init  <= s1_init;
      s2_sum   <= ACC_W_p'(tree_sum);
    end
  end

  // Stage S3: accumulator and tile-loop FSM. A beat seen in IDLE always
  // restarts from fm_init, as does any explicit first (abandoning a partial).
  acc_state_e                state;
  logic signed [ACC_W_p-1:0] acc;
  logic signed [ACC_W_p-1:0] acc_next;
  logic signed [ACC_W_p-1:0] init_ext;
  logic                      restart;
  logic                      s3_emit;

  always_comb begin
    restart  = s2_first || (state == IDLE);
    init_ext = ACC_W_p'(s2_init) <<< FRAC_p;
    acc_next = restart ? (init_ext + s2_sum) : (acc + s2_sum);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      acc     <= '0;
      s3_emit <= 1'b0;
    end else if (advance) begin
      s3_emit <= s2_valid && s2_last;
      if (s2_valid) begin
        acc   <= acc_next;
        state <= s2_last ? IDLE : ACC;
      end
    end
  end

  assign acc_state_o = state;

  // Output register: rounds the finished sum held in acc the cycle after the
  // last beat, so a later beat updating acc on the same edge cannot disturb it.
  round_sat_t rs;
  logic       unused_rs_hi;

  always_comb begin
    rs = round_sat(RS_ACC_W'(acc), FRAC_p, W_p);
  end

  assign unused_rs_hi = ^rs.value[RS_VAL_W-1:W_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_o <= 1'b0;
      fm_o    <= '0;
      sat_o   <= 1'b0;
    end else if (advance) begin
      valid_o <= s3_emit;
      if (s3_emit) begin
        fm_o  <= rs.value[W_p-1:0];
        sat_o <= rs.sat;
      end
    end
  end

endmodule

// File: tb/tb_input_loop_mac.sv
// Directed bench for input_loop_mac with Tn=2, W=16, FRAC=8 (Q8.8 data).
module tb_input_loop_mac;
  import input_loop_pkg::*;

  logic             clk_i;
  logic             reset_n_i;
  logic             valid_i;
  logic             ready_o;
  logic             first_i;
  logic             last_i;
  logic [1:0][15:0] fm_i;
  logic [1:0][15:0] weights_i;
  logic [15:0]      fm_init_i;
  logic             valid_o;
  logic             ready_i;
  logic [15:0]      fm_o;
  logic             sat_o;
  acc_state_e       acc_state;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [16:0] exp_q[$];

  input_loop_mac #(
    .Tn_p    (2),
    .W_p     (16),
    .FRAC_p  (8),
    .ACC_W_p (40)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .first_i     (first_i),
    .last_i      (last_i),
    .fm_i        (fm_i),
    .weights_i   (weights_i),
    .fm_init_i   (fm_init_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .fm_o        (fm_o),
    .sat_o       (sat_o),
    .acc_state_o (acc_state)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: present a beat and hold it until accepted
  task automatic send(input logic f, input logic l, input logic [15:0] f0, input logic [15:0] f1,
                      input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] init);
    logic accepted;
    valid_i      = 1'b1;
    first_i      = f;
    last_i       = l;
    fm_i[0]      = f0;
    fm_i[1]      = f1;
    weights_i[0] = w0;
    weights_i[1] = w1;
    fm_init_i    = init;
    accepted     = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) begin
      @(negedge clk_i);
      accepted = ready_o;
      @(posedge clk_i);
      #1;
    end
    chk("send_accept", 32'(accepted), 32'd1);
  endtask

  task automatic idle();
    valid_i = 1'b0;
    first_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // scoreboard: wait (bounded) for the next result and compare to the queue
  task automatic expect_next(input string tag);
    logic [16:0] exp;
    for (int n = 0; n < 20 && !valid_o; n++) begin
      @(posedge clk_i);
      #1;
    end
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    exp = exp_q.pop_front();
    chk(tag, {15'd0, sat_o, fm_o}, {15'd0, exp});
    @(posedge clk_i);
    #1;
  endtask

  task automatic count_results(input int cycles, output int seen);
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      if (valid_o) seen++;
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int seen;
    reset_n_i = 1'b0;
    ready_i   = 1'b1;
    fm_i      = '0;
    weights_i = '0;
    fm_init_i = '0;
    idle();
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_fm_o", 32'(fm_o), 32'd0);
    chk("rst_sat_o", 32'(sat_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_state", 32'(acc_state), 32'(IDLE));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // single tile: 2.0*1.5 + 0.5*4.0 = 5.0, valid three edges after accept
    send(1, 1, 16'h0200, 16'h0080, 16'h0180, 16'h0400, 16'h0000);
    idle();
    chk("lat_k0", 32'(valid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("lat_k1", 32'(valid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("lat_k2", 32'(valid_o), 32'd0);
    @(posedge clk_i); #1;
    chk("lat_k3", 32'(valid_o), 32'd1);
    chk("single_fm", 32'(fm_o), 32'h0500);
    chk("single_sat", 32'(sat_o), 32'd0);
    @(posedge clk_i); #1;
    chk("single_clear", 32'(valid_o), 32'd0);

    // three tiles from init 1.0, each adding 1*1 + 1*2 = 3.0
    send(1, 0, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0100);
    send(0, 0, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h7F00);
    send(0, 1, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h7F00);
    idle();
    exp_q.push_back({1'b0, 16'h0A00});
    expect_next("three_tile");
    count_results(5, seen);
    chk("three_tile_once", 32'(seen), 32'd0);

    // saturation: +225.0 and -225.0
    send(1, 1, 16'h1400, 16'h0500, 16'h0A00, 16'h0500, 16'h0000);
    send(1, 1, 16'hEC00, 16'hFB00, 16'h0A00, 16'h0500, 16'h0000);
    idle();
    exp_q.push_back({1'b1, 16'h7FFF});
    exp_q.push_back({1'b1, 16'h8000});
    expect_next("sat_pos");
    expect_next("sat_neg");

    // rounding at raw +0x80, -0x80 and -0x81, back to back
    send(1, 1, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 16'h0000);
    send(1, 1, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 16'h0000);
    send(1, 1, 16'hFFFF, 16'h0000, 16'h0081, 16'h0000, 16'h0000);
    idle();
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b0, 16'hFFFF});
    expect_next("round_half_pos");
    expect_next("round_half_neg");
    expect_next("round_below_neg");

    // backpressure: three pixels queued behind a stalled output
    ready_i = 1'b0;
    send(1, 1, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000);
    send(1, 1, 16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0000);
    send(1, 1, 16'h0100, 16'h0000, 16'h0300, 16'h0000, 16'h0000);
    idle();
    @(posedge clk_i); #1;
    chk("bp_first_valid", 32'(valid_o), 32'd1);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk_i); #1;
      chk("bp_ready_o", 32'(ready_o), 32'd0);
      chk("bp_fm_held", 32'(fm_o), 32'h0100);
    end
    ready_i = 1'b1;
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b0, 16'h0200});
    exp_q.push_back({1'b0, 16'h0300});
    expect_next("bp_a");
    expect_next("bp_b");
    expect_next("bp_c");
    chk("bp_drained", 32'(valid_o), 32'd0);

    // restart: a first beat in ACC drops the partial 4.0
    send(1, 0, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0100);
    send(1, 1, 16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0000);
    idle();
    exp_q.push_back({1'b0, 16'h0200});
    expect_next("restart");
    count_results(5, seen);
    chk("restart_once", 32'(seen), 32'd0);

    // reset mid-pixel with a last beat in flight
    send(1, 0, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100);
    send(0, 0, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000);
    idle();
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    chk("mid_state_acc", 32'(acc_state), 32'(ACC));
    send(0, 1, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000);
    idle();
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_valid_o", 32'(valid_o), 32'd0);
    chk("mid_rst_fm_o", 32'(fm_o), 32'd0);
    chk("mid_rst_sat_o", 32'(sat_o), 32'd0);
    chk("mid_rst_ready_o", 32'(ready_o), 32'd1);
    chk("mid_rst_state", 32'(acc_state), 32'(IDLE));
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    count_results(6, seen);
    chk("mid_rst_no_result", 32'(seen), 32'd0);

    // beat in IDLE without first still loads init: 3.0 + 1.0
    send(0, 1, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0300);
    idle();
    exp_q.push_back({1'b0, 16'h0400});
    expect_next("post_reset_pixel");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/input_loop_mac.md
# input_loop_mac

Pipelined, parametrised successor to the combinational input-loop multiply-sum. It multiplies `Tn_p` input-feature-map lanes by `Tn_p` weights and reduces the products through a registered adder tree. It accumulates the result across successive input-channel tiles, the `ti` loop, starting from an initial output-fm value, and emits one rounded, saturated output pixel per tile sequence. It sits between the input/weight tile buffers and the output-fm buffer in the conv engine, and uses signed fixed point instead of `shortreal`.

## Interface
- `Tn_p`, default 4: lanes per beat (≥1).
- `W_p`, default 16: signed data width of fm, weight, init and output.
- `FRAC_p`, default 8: fractional bits, 0 < `FRAC_p` < `W_p`.
- `ACC_W_p`, default 40: accumulator width, ≥ 2·`W_p`+$clog2(`Tn_p`)+1.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: input beat valid.
- `ready_o` out 1: beat accepted when `valid_i` && `ready_o`.
- `first_i` in 1: beat is the first tile of a pixel; load `fm_init_i`.
- `last_i` in 1: beat is the last tile; emit result.
- `fm_i` in `Tn_p`×`W_p`: input fm lanes.
- `weights_i` in `Tn_p`×`W_p`: weight lanes.
- `fm_init_i` in `W_p`: initial output value; sampled only with `first_i`.
- `valid_o` out 1: result valid.
- `ready_i` in 1: downstream accepts the result.
- `fm_o` out `W_p`: rounded, saturated result.
- `sat_o` out 1: `fm_o` was clipped; qualified by `valid_o`.

## Operation
- Stage S1 registers the `Tn_p` products, each 2·`W_p` signed at 2·`FRAC_p` fraction, together with `first`, `last`, `fm_init` and a valid bit.
- Stage S2 registers the adder-tree sum, sign-extended to `ACC_W_p`.
- Stage S3 accumulates:
  - if `first`: `acc_next` = (`fm_init` sign-extended <<< `FRAC_p`) + `sum`.
  - otherwise: `acc_next` = `acc` + `sum`.
  - The accumulator wraps at `ACC_W_p` bits. It is sized so that wrapping cannot occur within spec.
- The accumulator FSM has two states, IDLE and ACC:
  - IDLE → ACC on an S3 beat with `!last`.
  - ACC → IDLE on an S3 beat with `last`.
  - A beat arriving in IDLE without `first` is treated as `first`.
  - A `first` beat arriving in ACC discards the old partial sum and restarts. No output is produced for the abandoned pixel.
  - `first` && `last` on the same beat produces a single-tile pixel.
- Output, on an S3 `last` beat:
  - r = (`acc_next` + 2^(`FRAC_p`−1)) >>> `FRAC_p`, i.e. round half up.
  - r is clipped to [−2^(`W_p`−1), 2^(`W_p`−1)−1].
  - `sat_o` = 1 if clipped.
  - The output register loads, and `valid_o` is set.

## Timing
- Reset values: `valid_o`=0, `fm_o`=0, `sat_o`=0, `ready_o`=1; all stage valids 0; `acc`=0; FSM in IDLE.
- Stall control:
  - `advance` = !`valid_o` || `ready_i`; `ready_o` = `advance`.
  - When `advance`=0, every stage, the accumulator and the output register hold.
- `valid_o`:
  - clears on `valid_o` && `ready_i` unless a new result loads on the same edge, in which case the new result replaces the old.
  - `fm_o` is stable while `valid_o` && !`ready_i`.
- Latency: a `last` beat accepted at edge k gives `valid_o`=1 after edge k+3, assuming no stalls.
- Throughput: one beat per cycle. Back-to-back single-tile pixels produce one result per cycle.
- Bubbles (`valid_i`=0) propagate and do not touch `acc`.
- Reset mid-operation clears all in-flight beats and any partial sum immediately. No result is emitted for them.

## Structure
- Package `input_loop_pkg`:
  - width-derived localparams: product width, tree width.
  - the state enum `acc_state_e` {IDLE, ACC}.
  - a function `round_sat(acc, FRAC, W)` returning {sat, value}.
- Sub-module `adder_tree`:
  - parametrised by N and width; purely combinational.
  - pads a non-power-of-two N with zeros.
  - output width = in width + $clog2(N).

## Test plan
All cases use `Tn_p`=2, `W_p`=16 and `FRAC_p`=8 unless noted; hex values are Q8.8.

- **Single tile:** fm {2.0, 0.5}, weights {1.5, 4.0}, init 0, `first`=`last`=1 -> `fm_o`=0x0500 (5.0), `sat_o`=0, `valid_o` after 3 edges.
- **Three-tile accumulate:** init 1.0, three beats each with fm {1.0, 1.0} and weights {1.0, 2.0} -> 10.0 (0x0A00). Exactly one result, produced on the `last` beat.
- **Saturation:** fm {20.0, 5.0}, weights {10.0, 5.0}, single tile -> `fm_o`=0x7FFF, `sat_o`=1. The negated case gives 0x8000, `sat_o`=1.
- **Rounding:** products summing to raw 0x0080 at FRAC 8 (0.5 LSB) -> `fm_o`=1 LSB. −0.5 LSB -> 0.
- **Backpressure:** `ready_i`=0 for 5 cycles with results pending -> `ready_o`=0, `fm_o` held, no beat lost. Three back-to-back pixels complete in order after release.
- **Restart/reset:** a `first` beat in ACC -> the old sum is dropped. Asserting `reset_n_i` mid-pixel -> outputs return to their reset values, and the next pixel is correct.
